// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with stall hold, flush bubble and a saturating stall-age counter.
// Optional performance counters are enabled by defining PIPE_PERF_EN.
module pipe_stage_reg #(
  parameter int unsigned DATA_W    = 96,
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic              bd_in,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       instr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  output logic              bd_out,
  output logic [31:0]       pc_out,
  output logic [31:0]       instr_out,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  stall_age,
  output logic [31:0]       perf_valid_cnt,
  output logic [31:0]       perf_bubble_cnt
);

  localparam logic [CNT_W-1:0] AgeMax = '1;

  logic              valid_q, valid_d;
  logic              bd_q, bd_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  age_q, age_d;

  // Reset is applied in the flop block; this covers flush > stall > load.
  always_comb begin
    valid_d = valid_q;
    bd_d    = bd_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    data_d  = data_q;
    age_d   = age_q;
    if (flush) begin
      // Bubble keeps the victim's PC and delay-slot flag so a later EPC is correct.
      valid_d = 1'b0;
      bd_d    = bd_in;
      pc_d    = pc_in;
      instr_d = NOP_INSTR;
      data_d  = '0;
      age_d   = '0;
    end else if (stall) begin
      if (age_q != AgeMax) begin
        age_d = age_q + 1'b1;
      end
    end else begin
      valid_d = valid_in;
      bd_d    = bd_in;
      pc_d    = pc_in;
      instr_d = instr_in;
      data_d  = data_in;
      age_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      bd_q    <= 1'b0;
      pc_q    <= PC_RESET;
      instr_q <= NOP_INSTR;
      data_q  <= '0;
      age_q   <= '0;
    end else begin
      valid_q <= valid_d;
      bd_q    <= bd_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      data_q  <= data_d;
      age_q   <= age_d;
    end
  end

  assign valid_out = valid_q;
  assign bd_out    = bd_q;
  assign pc_out    = pc_q;
  assign instr_out = instr_q;
  assign data_out  = data_q;
  assign stall_age = age_q;

`ifdef PIPE_PERF_EN
  logic [31:0] perf_valid_q;
  logic [31:0] perf_bubble_q;

  // Valid count samples valid_out as it was before the edge; both wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_valid_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      if (valid_q) begin
        perf_valid_q <= perf_valid_q + 32'd1;
      end
      if (flush) begin
        perf_bubble_q <= perf_bubble_q + 32'd1;
      end
    end
  end

  assign perf_valid_cnt  = perf_valid_q;
  assign perf_bubble_cnt = perf_bubble_q;
`else
  assign perf_valid_cnt  = 32'h0;
  assign perf_bubble_cnt = 32'h0;
`endif

`ifndef SYNTHESIS
  a_flush_bubble : assert property (@(posedge clk) (flush && !reset) |=> (!valid_out && instr_out == NOP_INSTR))
    else $error("flush did not produce a bubble");
  a_reset_pc : assert property (@(posedge clk) reset |=> (pc_out == PC_RESET && stall_age == '0))
    else $error("reset values not applied");
`endif

endmodule
